// File: rtl/axi4_stream_pkt_fifo.sv
// axi4_stream_pkt_fifo
// First-word-fall-through AXI4-Stream FIFO with optional store-and-forward.
// Handshake rule: a beat transfers on a rising clk edge where tvalid and tready
// are both high; once axi_m_tvalid_o is high it and the axi_m_* payload stay
// stable until that transfer happens. axi_s_tready_o comes straight from a
// register, so there is no combinational path from axi_m_tready_i to it.
// In store-and-forward mode the read side only presents data once a whole
// packet (tlast) is stored. The exception is a packet too large to fit: when
// the buffer is full without any tlast stored, the release flag lets that
// packet stream out cut-through until its tlast is read.
module axi4_stream_pkt_fifo #(
   parameter int TDATA_L  = 512,
   parameter int TUSER_L  = 81,
   parameter int TKEEP_L  = 16,
   parameter int DEPTH    = 16,
   parameter int PKT_MODE = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [TDATA_L-1:0]         axi_s_tdata_i,
   input  logic [TUSER_L-1:0]         axi_s_tuser_i,
   input  logic                       axi_s_tlast_i,
   input  logic [TKEEP_L-1:0]         axi_s_tkeep_i,
   input  logic                       axi_s_tvalid_i,
   output logic                       axi_s_tready_o,
   output logic [TDATA_L-1:0]         axi_m_tdata_o,
   output logic [TUSER_L-1:0]         axi_m_tuser_o,
   output logic                       axi_m_tlast_o,
   output logic [TKEEP_L-1:0]         axi_m_tkeep_o,
   output logic                       axi_m_tvalid_o,
   input  logic                       axi_m_tready_i,
   output logic [$clog2(DEPTH):0]     fifo_count_o,
   output logic [$clog2(DEPTH):0]     pkt_count_o,
   output logic                       overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = TDATA_L + TUSER_L + TKEEP_L + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Entry layout: {tdata, tuser, tkeep, tlast}; tlast sits in bit 0.
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] rd_word;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] pkt_count;
   logic [CW-1:0] fifo_count_nxt;
   logic [CW-1:0] pkt_count_nxt;
   logic          s_tready_q;
   logic          release_q;
   logic          overflow_q;
   logic          m_tvalid;
   logic          wr_en;
   logic          rd_en;
   logic          wr_last;
   logic          rd_last;

   assign rd_word = mem[rd_ptr];
   assign wr_en   = axi_s_tvalid_i & s_tready_q;
   assign rd_en   = m_tvalid & axi_m_tready_i;
   assign wr_last = wr_en & axi_s_tlast_i;
   assign rd_last = rd_en & rd_word[0];

   // Read-side valid: whole packet stored (or oversize release) in packet mode,
   // any stored beat in cut-through mode.
   always_comb begin
      m_tvalid = 1'b0;
      if (PKT_MODE != 0) begin
         m_tvalid = (fifo_count != '0) && ((pkt_count != '0) || release_q);
      end else begin
         m_tvalid = (fifo_count != '0);
      end
   end

   // Next beat and packet counts; a write and a read in the same cycle cancel.
   always_comb begin
      fifo_count_nxt = fifo_count;
      pkt_count_nxt  = pkt_count;
      case ({wr_en, rd_en})
         2'b10:   fifo_count_nxt = fifo_count + CW'(1);
         2'b01:   fifo_count_nxt = fifo_count - CW'(1);
         default: fifo_count_nxt = fifo_count;
      endcase
      case ({wr_last, rd_last})
         2'b10:   pkt_count_nxt = pkt_count + CW'(1);
         2'b01:   pkt_count_nxt = pkt_count - CW'(1);
         default: pkt_count_nxt = pkt_count;
      endcase
   end

   // Storage array: written only on an accepted beat, never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {axi_s_tdata_i, axi_s_tuser_i, axi_s_tkeep_i, axi_s_tlast_i};
      end
   end

   // Pointers, counts, registered ready, release and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         pkt_count  <= '0;
         s_tready_q <= 1'b0;
         release_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fifo_count <= fifo_count_nxt;
         pkt_count  <= pkt_count_nxt;
         s_tready_q <= (fifo_count_nxt != FULL_CNT);
         if (PKT_MODE != 0) begin
            if (rd_last) begin
               release_q <= 1'b0;
            end else if ((fifo_count == FULL_CNT) && (pkt_count == '0)) begin
               release_q <= 1'b1;
            end
         end
         if (axi_s_tvalid_i && (fifo_count == FULL_CNT)) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Payload is forced to zero whenever nothing is presented (including reset).
   assign {axi_m_tdata_o, axi_m_tuser_o, axi_m_tkeep_o, axi_m_tlast_o} =
      m_tvalid ? rd_word : '0;

   assign axi_m_tvalid_o = m_tvalid;
   assign axi_s_tready_o = s_tready_q;
   assign fifo_count_o   = fifo_count;
   assign pkt_count_o    = pkt_count;
   assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_axi4_stream_pkt_fifo.sv
// Directed bench for axi4_stream_pkt_fifo: a store-and-forward instance with
// default widths and a small cut-through instance sharing clock and reset.
module tb_axi4_stream_pkt_fifo;

   logic clk;
   logic rst_n;

   // store-and-forward instance
   logic [511:0] s_data;
   logic [80:0]  s_user;
   logic         s_last;
   logic [15:0]  s_keep;
   logic         s_valid;
   logic         s_ready;
   logic [511:0] m_data;
   logic [80:0]  m_user;
   logic         m_last;
   logic [15:0]  m_keep;
   logic         m_valid;
   logic         m_ready;
   logic [4:0]   f_cnt;
   logic [4:0]   p_cnt;
   logic         ovf;

   // cut-through instance
   logic [31:0]  c_data;
   logic [7:0]   c_user;
   logic         c_last;
   logic [3:0]   c_keep;
   logic         c_valid;
   logic         c_s_ready;
   logic [31:0]  c_m_data;
   logic [7:0]   c_m_user;
   logic         c_m_last;
   logic [3:0]   c_m_keep;
   logic         c_m_valid;
   logic         c_m_ready;
   logic [4:0]   c_f_cnt;
   logic [4:0]   c_p_cnt;
   logic         c_ovf;

   int n_cmp;
   int n_err;

   axi4_stream_pkt_fifo u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .axi_s_tdata_i  (s_data),
      .axi_s_tuser_i  (s_user),
      .axi_s_tlast_i  (s_last),
      .axi_s_tkeep_i  (s_keep),
      .axi_s_tvalid_i (s_valid),
      .axi_s_tready_o (s_ready),
      .axi_m_tdata_o  (m_data),
      .axi_m_tuser_o  (m_user),
      .axi_m_tlast_o  (m_last),
      .axi_m_tkeep_o  (m_keep),
      .axi_m_tvalid_o (m_valid),
      .axi_m_tready_i (m_ready),
      .fifo_count_o   (f_cnt),
      .pkt_count_o    (p_cnt),
      .overflow_o     (ovf)
   );

   axi4_stream_pkt_fifo #(
      .TDATA_L  (32),
      .TUSER_L  (8),
      .TKEEP_L  (4),
      .DEPTH    (16),
      .PKT_MODE (0)
   ) u_ct (
      .clk            (clk),
      .rst_n          (rst_n),
      .axi_s_tdata_i  (c_data),
      .axi_s_tuser_i  (c_user),
      .axi_s_tlast_i  (c_last),
      .axi_s_tkeep_i  (c_keep),
      .axi_s_tvalid_i (c_valid),
      .axi_s_tready_o (c_s_ready),
      .axi_m_tdata_o  (c_m_data),
      .axi_m_tuser_o  (c_m_user),
      .axi_m_tlast_o  (c_m_last),
      .axi_m_tkeep_o  (c_m_keep),
      .axi_m_tvalid_o (c_m_valid),
      .axi_m_tready_i (c_m_ready),
      .fifo_count_o   (c_f_cnt),
      .pkt_count_o    (c_p_cnt),
      .overflow_o     (c_ovf)
   );

   // clock: 10 time-unit period, first rising edge at t=5
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [511:0] mk_data(input int k);
      return {16{32'(k) ^ 32'hA5A5_0000}};
   endfunction

   function automatic logic [80:0] mk_user(input int k);
      return {17'(k), 32'hC0DE_0000, 32'(k)};
   endfunction

   function automatic logic [15:0] mk_keep(input int k);
      return 16'(k * 3 + 1);
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are then sampled 1 unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int k, input logic last);
      s_data = mk_data(k);
      s_user = mk_user(k);
      s_keep = mk_keep(k);
      s_last = last;
   endtask

   task automatic chk_beat(input string tag, input int k, input logic last);
      chk({tag, "_data"}, m_data, mk_data(k));
      chk({tag, "_user"}, 512'(m_user), 512'(mk_user(k)));
      chk({tag, "_keep"}, 512'(m_keep), 512'(mk_keep(k)));
      chk({tag, "_last"}, 512'(m_last), 512'(last));
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      s_data    = '0;
      s_user    = '0;
      s_last    = 1'b0;
      s_keep    = '0;
      s_valid   = 1'b0;
      m_ready   = 1'b0;
      c_data    = '0;
      c_user    = '0;
      c_last    = 1'b0;
      c_keep    = '0;
      c_valid   = 1'b0;
      c_m_ready = 1'b0;

      // reset state
      #2;
      chk("rst_tready", 512'(s_ready), 512'(0));
      chk("rst_tvalid", 512'(m_valid), 512'(0));
      chk("rst_fcnt", 512'(f_cnt), 512'(0));
      chk("rst_pcnt", 512'(p_cnt), 512'(0));
      chk("rst_ovf", 512'(ovf), 512'(0));
      chk("rst_tdata", m_data, 512'(0));
      chk("rst_tlast", 512'(m_last), 512'(0));
      #10;
      rst_n = 1'b1;
      step();
      chk("post_rst_tready", 512'(s_ready), 512'(1));
      chk("post_rst_ct_tready", 512'(c_s_ready), 512'(1));

      // cut-through: one beat visible exactly one cycle after the write
      c_data  = 32'hDEAD_BEEF;
      c_last  = 1'b1;
      c_valid = 1'b1;
      chk("ct_pre_tvalid", 512'(c_m_valid), 512'(0));
      step();
      c_valid = 1'b0;
      chk("ct_tvalid", 512'(c_m_valid), 512'(1));
      chk("ct_fcnt", 512'(c_f_cnt), 512'(1));
      chk("ct_tdata", 512'(c_m_data), 512'(32'hDEAD_BEEF));
      chk("ct_tlast", 512'(c_m_last), 512'(1));
      c_m_ready = 1'b1;
      step();
      chk("ct_drain_tvalid", 512'(c_m_valid), 512'(0));
      chk("ct_drain_fcnt", 512'(c_f_cnt), 512'(0));

      // store-and-forward: 3-beat packet held until tlast stored
      m_ready = 1'b1;
      set_beat(1, 1'b0);
      s_valid = 1'b1;
      step();
      chk("sf_b1_fcnt", 512'(f_cnt), 512'(1));
      chk("sf_b1_tvalid", 512'(m_valid), 512'(0));
      set_beat(2, 1'b0);
      step();
      chk("sf_b2_fcnt", 512'(f_cnt), 512'(2));
      chk("sf_b2_tvalid", 512'(m_valid), 512'(0));
      set_beat(3, 1'b1);
      step();
      s_valid = 1'b0;
      chk("sf_b3_fcnt", 512'(f_cnt), 512'(3));
      chk("sf_b3_pcnt", 512'(p_cnt), 512'(1));
      chk("sf_b3_tvalid", 512'(m_valid), 512'(1));
      chk_beat("sf_out1", 1, 1'b0);
      step();
      chk_beat("sf_out2", 2, 1'b0);
      step();
      chk_beat("sf_out3", 3, 1'b1);
      step();
      chk("sf_end_fcnt", 512'(f_cnt), 512'(0));
      chk("sf_end_pcnt", 512'(p_cnt), 512'(0));
      chk("sf_end_tvalid", 512'(m_valid), 512'(0));

      // oversize packet: 16 beats without tlast fill the buffer, release opens it
      for (int k = 0; k < 16; k++) begin
         set_beat(100 + k, 1'b0);
         s_valid = 1'b1;
         step();
      end
      s_valid = 1'b0;
      chk("big_full_fcnt", 512'(f_cnt), 512'(16));
      chk("big_full_tready", 512'(s_ready), 512'(0));
      chk("big_full_tvalid", 512'(m_valid), 512'(0));
      step();
      chk("big_rel_tvalid", 512'(m_valid), 512'(1));
      chk("big_rel_ovf", 512'(ovf), 512'(0));
      for (int i = 0; i < 16; i++) begin
         chk("big_drain_data", m_data, mk_data(100 + i));
         step();
      end
      chk("big_drained_fcnt", 512'(f_cnt), 512'(0));
      chk("big_drained_tvalid", 512'(m_valid), 512'(0));
      set_beat(116, 1'b1);
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      chk("big_tail_pcnt", 512'(p_cnt), 512'(1));
      chk_beat("big_tail", 116, 1'b1);
      step();
      chk("big_tail_fcnt", 512'(f_cnt), 512'(0));
      // release must be closed now: a lone non-tlast beat stays hidden
      set_beat(117, 1'b0);
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      chk("rel_clr_fcnt", 512'(f_cnt), 512'(1));
      chk("rel_clr_tvalid", 512'(m_valid), 512'(0));
      set_beat(118, 1'b1);
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      chk("rel_pkt_tvalid", 512'(m_valid), 512'(1));
      chk_beat("rel_pkt_b0", 117, 1'b0);
      step();
      chk_beat("rel_pkt_b1", 118, 1'b1);
      step();
      chk("rel_pkt_fcnt", 512'(f_cnt), 512'(0));

      // overflow: fill with reader stalled, keep pushing while full
      m_ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
         set_beat(200 + k, 1'b1);
         s_valid = 1'b1;
         step();
      end
      chk("ovf_full_fcnt", 512'(f_cnt), 512'(16));
      chk("ovf_full_pcnt", 512'(p_cnt), 512'(16));
      chk("ovf_full_tready", 512'(s_ready), 512'(0));
      chk("ovf_pre_ovf", 512'(ovf), 512'(0));
      set_beat(216, 1'b1);
      step();
      chk("ovf_set", 512'(ovf), 512'(1));
      chk("ovf_fcnt_hold", 512'(f_cnt), 512'(16));
      chk_beat("ovf_head_hold", 200, 1'b1);
      step();
      chk("ovf_sticky", 512'(ovf), 512'(1));
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("ovf_drain_data", m_data, mk_data(200 + i));
         step();
         if (i == 0) begin
            chk("full_read_tready", 512'(s_ready), 512'(1));
         end
      end
      chk("ovf_drained_fcnt", 512'(f_cnt), 512'(0));
      chk("ovf_drained_pcnt", 512'(p_cnt), 512'(0));
      chk("ovf_drained_tvalid", 512'(m_valid), 512'(0));
      chk("ovf_still_set", 512'(ovf), 512'(1));

      // steady state: 5 stored, simultaneous read and write for 20 cycles
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_beat(300 + k, 1'b1);
         s_valid = 1'b1;
         step();
      end
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_beat(305 + i, 1'b1);
         chk("ss_head", m_data, mk_data(300 + i));
         step();
         chk("ss_fcnt", 512'(f_cnt), 512'(5));
         chk("ss_pcnt", 512'(p_cnt), 512'(5));
      end
      s_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("ss_drain", m_data, mk_data(320 + i));
         step();
      end
      chk("ss_end_fcnt", 512'(f_cnt), 512'(0));

      // asynchronous reset mid-packet with 7 beats stored
      for (int k = 0; k < 7; k++) begin
         set_beat(400 + k, 1'b0);
         s_valid = 1'b1;
         step();
      end
      s_valid = 1'b0;
      chk("mid_fcnt", 512'(f_cnt), 512'(7));
      chk("mid_tvalid", 512'(m_valid), 512'(0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_fcnt", 512'(f_cnt), 512'(0));
      chk("arst_pcnt", 512'(p_cnt), 512'(0));
      chk("arst_tready", 512'(s_ready), 512'(0));
      chk("arst_tvalid", 512'(m_valid), 512'(0));
      chk("arst_tdata", m_data, 512'(0));
      chk("arst_tuser", 512'(m_user), 512'(0));
      chk("arst_tkeep", 512'(m_keep), 512'(0));
      chk("arst_tlast", 512'(m_last), 512'(0));
      chk("arst_ovf", 512'(ovf), 512'(0));
      rst_n = 1'b1;
      step();
      chk("arst_rel_tready", 512'(s_ready), 512'(1));
      chk("arst_rel_fcnt", 512'(f_cnt), 512'(0));
      chk("arst_rel_tvalid", 512'(m_valid), 512'(0));
      set_beat(500, 1'b0);
      s_valid = 1'b1;
      step();
      set_beat(501, 1'b1);
      step();
      s_valid = 1'b0;
      chk("post_fcnt", 512'(f_cnt), 512'(2));
      chk("post_pcnt", 512'(p_cnt), 512'(1));
      chk("post_tvalid", 512'(m_valid), 512'(1));
      chk_beat("post_b0", 500, 1'b0);
      step();
      chk_beat("post_b1", 501, 1'b1);
      step();
      chk("post_end_fcnt", 512'(f_cnt), 512'(0));
      chk("post_end_tvalid", 512'(m_valid), 512'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi4_stream_pkt_fifo.md
AXI4_STREAM_PKT_FIFO -- requirements
Module: axi4_stream_pkt_fifo

Interface
REQ-001 The block SHALL have parameter TDATA_L, default 512: tdata width in bits.
REQ-002 The block SHALL have parameter TUSER_L, default 81: tuser width in bits.
REQ-003 The block SHALL have parameter TKEEP_L, default 16: tkeep width in bits.
REQ-004 The block SHALL have parameter DEPTH, default 16: entry count; it is a power of two and at least 4.
REQ-005 The block SHALL have parameter PKT_MODE, default 1: 1 = store-and-forward, 0 = cut-through.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have ports axi_s_tdata_i / axi_s_tuser_i / axi_s_tlast_i / axi_s_tkeep_i, input, widths TDATA_L / TUSER_L / 1 / TKEEP_L: write-side beat, fed by the upstream 2:1 switch master port.
REQ-010 The block SHALL have port axi_s_tvalid_i, input, 1 bit, and port axi_s_tready_o, output, 1 bit: write-side handshake.
REQ-011 The block SHALL have ports axi_m_tdata_o / axi_m_tuser_o / axi_m_tlast_o / axi_m_tkeep_o, output, same widths as REQ-009: read-side beat.
REQ-012 The block SHALL have port axi_m_tvalid_o, output, 1 bit, and port axi_m_tready_i, input, 1 bit: read-side handshake.
REQ-013 The block SHALL have port fifo_count_o, output, $clog2(DEPTH)+1 bits: stored beat count.
REQ-014 The block SHALL have port pkt_count_o, output, $clog2(DEPTH)+1 bits: count of complete packets (tlast stored) held.
REQ-015 The block SHALL have port overflow_o, output, 1 bit: sticky flag; set on tvalid while full.

Function
REQ-016 A write SHALL occur when axi_s_tvalid_i and axi_s_tready_o are both high; a read SHALL occur when axi_m_tvalid_o and axi_m_tready_i are both high.
REQ-017 axi_s_tready_o SHALL equal (fifo_count_o != DEPTH), driven from a register; there is no combinational path from axi_m_tready_i.
REQ-018 The buffer SHALL be first-word-fall-through: a beat written into an empty FIFO at edge N appears on axi_m_* with axi_m_tvalid_o high after edge N, i.e. one-cycle latency; there is no same-cycle bypass.
REQ-019 fifo_count_o SHALL change by +1 on write only, -1 on read only, and 0 on simultaneous write and read; pointers wrap modulo DEPTH.
REQ-020 pkt_count_o SHALL change by +1 on a write with tlast, -1 on a read with tlast, and 0 when both occur in the same cycle.
REQ-021 When PKT_MODE=1, axi_m_tvalid_o SHALL be (fifo_count_o != 0) AND (pkt_count_o != 0 OR release).
REQ-022 In PKT_MODE=1, release SHALL set when fifo_count_o == DEPTH and pkt_count_o == 0 (oversize packet; cut-through fallback), and SHALL clear on a read with tlast.
REQ-023 When PKT_MODE=0, axi_m_tvalid_o SHALL equal (fifo_count_o != 0).
REQ-024 Once axi_m_tvalid_o is high, it and axi_m_* data SHALL be held stable until a read occurs.
REQ-025 overflow_o SHALL set at the edge where axi_s_tvalid_i is high while full, and SHALL clear only on reset.
REQ-026 tdata, tuser, tkeep and tlast SHALL be stored and returned bit-exact; the block SHALL NOT modify or inspect tkeep.
REQ-027 A write SHALL be accepted in the same cycle as a read from a full FIFO only if tready was already high; full-and-read SHALL give ready the next cycle.

Reset
REQ-028 While rst_n is low: pointers, fifo_count_o, pkt_count_o, release and overflow_o SHALL be 0; axi_s_tready_o, axi_m_tvalid_o and axi_m_tlast_o SHALL be 0; axi_m_tdata_o, axi_m_tuser_o and axi_m_tkeep_o SHALL be 0.
REQ-029 axi_s_tready_o SHALL rise at the first clk edge after rst_n deasserts.
REQ-030 Assertion of rst_n mid-packet SHALL discard all stored beats immediately (asynchronous); no partial packet SHALL be emitted after reset.

Verification
REQ-031 Scenario PKT_MODE=1, DEPTH=16: write a 3-beat packet, tlast on beat 3, axi_m_tready_i=1 -> axi_m_tvalid_o stays 0 until the edge after beat 3, then 3 beats out in order; counts return to 0.
REQ-032 Scenario PKT_MODE=0: write 1 beat, tlast=1 -> axi_m_tvalid_o=1 exactly one cycle later; fifo_count_o=1 for that cycle.
REQ-033 Scenario PKT_MODE=1: write 16 beats with no tlast, axi_m_tready_i=1 -> axi_s_tready_o=0 when fifo_count_o=16; release sets; beats drain; a 17th beat with tlast completes the packet and release clears.
REQ-034 Scenario: fill to 16 with axi_m_tready_i=0 and hold axi_s_tvalid_i=1 -> overflow_o=1 sticky; axi_m_* unchanged; no beat lost or duplicated.
REQ-035 Scenario: steady state with fifo_count_o=5, simultaneous read and write of tlast beats for 20 cycles -> fifo_count_o=5 and pkt_count_o constant throughout.
REQ-036 Scenario: assert rst_n low mid-packet with fifo_count_o=7 -> all outputs reach their REQ-028 values without a clock edge; the first post-reset packet is output intact.
